vliw_regfile_mp: RTL and testbench
==================================

# vliw_regfile_mp

Parametrised multi-port register file for the VLIW datapath. It generalises the fixed-width, one- and two-write-source registers into a single block with DEPTH words of WIDTH bits, NUM_WR write ports and NUM_RD read ports. It adds deterministic write-collision priority, a registered collision flag with a collision counter, and an optional hardwired-zero r0. It sits between decode (read addresses) and writeback (write ports of all issue slots).

## Interface
- WIDTH, 32, data bits per word
- DEPTH, 8, number of words; power of two, 2..64
- NUM_RD, 4, read ports
- NUM_WR, 2, write ports (one per issue slot)
- AW, $clog2(DEPTH), address width (derived, not overridable)
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  reset, synchronous, active-high
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  packed write addresses, port p at [p*AW +: AW]
- wr_data  in  NUM_WR*WIDTH  packed write data
- rd_addr  in  NUM_RD*AW  packed read addresses
- rd_data  out  NUM_RD*WIDTH  packed read data, combinational
- wr_collision  out  1  registered: previous falling edge saw ≥2 enabled ports on one address
- collision_cnt  out  16  saturating count of collision edges

## Operation
- Storage: DEPTH x WIDTH words, each updated only on the falling edge of clk.
- Write resolution per word: among ports with wr_en[p] and wr_addr[p]==i, the highest port index wins. Lower ports to the same word are dropped.
- Writes to distinct words from different ports all commit on the same edge.
- Reset: on a falling edge with reset=1, all words, wr_collision and collision_cnt go to 0. Reset overrides any concurrent writes.
- wr_collision: set to 1 on an edge where any word has ≥2 enabled writers, otherwise 0. It is a one-edge pulse, held until the next falling edge.
- collision_cnt: increments by 1 on each collision edge and saturates at 16'hFFFF. It never wraps.
- Reads: rd_data[q] = word[rd_addr[q]]. Any number of ports may read the same address.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

## Timing
- Write-to-read latency: the new value appears on rd_data immediately after the committing falling edge, i.e. in the low half of the same clk cycle.
- Read path: purely combinational from rd_addr and stored words. No read enable.
- Reset mid-operation: the first falling edge with reset=1 clears everything. Writes presented during reset are lost. The first write is accepted on the first falling edge with reset=0.
- All outputs read 0 after reset, except rd_data, which reads 0 because all words are 0.

## Configuration
- VLIW_REGFILE_ZERO_R0_EN:
  - Defined: word 0 is hardwired to 0. Writes to address 0 are discarded, but they still participate in collision detection. Reads of address 0 always return 0.
  - Undefined: word 0 is an ordinary register.

## Structure
- Shared package vliw_regfile_pkg holds:
  - default constants REGFILE_WIDTH=32, REGFILE_DEPTH=8, REGFILE_NUM_RD=4, REGFILE_NUM_WR=2;
  - the collision counter width CNT_W=16;
  - a function computing the winning port index for a word from the per-port hit vector.
- One sub-module: regfile_word, a parametrised WIDTH-bit falling-edge register with synchronous reset and a write enable. The top instantiates DEPTH of them plus per-word winner-select muxes.

## Test plan
- Reset: hold reset for 2 edges, then read all 8 addresses on 4 ports -> all rd_data 0, wr_collision 0, collision_cnt 0.
- Parallel write: port0 writes 0xDEADBEEF to r3 and port1 writes 0x12345678 to r5 on one edge -> r3 and r5 read back as written, wr_collision 0.
- Collision: port0 writes 0x1111 to r4 and port1 writes 0x2222 to r4 -> r4 reads 0x2222, wr_collision 1 for one cycle, collision_cnt 1.
- Saturation: force 65540 collision edges -> collision_cnt stays 0xFFFF.
- Reset with write: assert reset while port1 writes 0xAAAA to r2 -> r2 reads 0. Deassert and rewrite -> r2 reads 0xAAAA after the next falling edge.
- Zero register (macro defined): write 0x5 to r0 -> r0 reads 0. Macro undefined: same stimulus -> r0 reads 0x5.

Source files
------------

// File: rtl/vliw_regfile_pkg.sv
// Shared constants and helpers for the VLIW multi-port register file.
// Build option: VLIW_REGFILE_ZERO_R0_EN (see vliw_regfile_mp.sv).
package vliw_regfile_pkg;

  localparam int REGFILE_WIDTH  = 32;
  localparam int REGFILE_DEPTH  = 8;
  localparam int REGFILE_NUM_RD = 4;
  localparam int REGFILE_NUM_WR = 2;
  localparam int CNT_W          = 16;
  localparam int MAX_WR         = 32;

  // Highest-indexed enabled port targeting a word wins the write.
  function automatic int unsigned winnerPort(input logic [MAX_WR-1:0] hits);
    winnerPort = 0;
    for (int p = 0; p < MAX_WR; p++) begin
      if (hits[p]) winnerPort = p;
    end
  endfunction

endpackage

// File: rtl/regfile_word.sv
// One WIDTH-bit storage word: falling-edge register, synchronous reset, write enable.
module regfile_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge clk) begin
    if (reset)     q <= '0;
    else if (wrEn) q <= wrData;
  end

endmodule

// File: rtl/vliw_regfile_mp.sv
// Multi-port register file with highest-port-wins write priority and collision tracking.
// Define VLIW_REGFILE_ZERO_R0_EN to hardwire word 0 to zero.
module vliw_regfile_mp
  import vliw_regfile_pkg::*;
#(
  parameter int WIDTH  = REGFILE_WIDTH,
  parameter int DEPTH  = REGFILE_DEPTH,
  parameter int NUM_RD = REGFILE_NUM_RD,
  parameter int NUM_WR = REGFILE_NUM_WR,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*AW-1:0]    wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic                    wr_collision,
  output logic [CNT_W-1:0]        collision_cnt
);

`ifdef VLIW_REGFILE_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  localparam int WR_IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [WIDTH-1:0] words [DEPTH];
  logic [DEPTH-1:0] multiHit;
  logic             anyCollision;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [NUM_WR-1:0] hits;

    always_comb begin
      hits = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        hits[p] = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(i));
      end
    end

    // Writes to a hardwired r0 are dropped but still count as collisions.
    assign multiHit[i] = ($countones(hits) > 1);

    if (ZERO_R0 && (i == 0)) begin : g_zero
      assign words[i] = '0;
    end else begin : g_reg
      logic [WR_IDX_W-1:0] win;
      assign win = WR_IDX_W'(winnerPort(MAX_WR'(hits)));

      regfile_word #(.WIDTH(WIDTH)) u_word (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (|hits),
        .wrData (wr_data[win*WIDTH +: WIDTH]),
        .q      (words[i])
      );
    end
  end

  assign anyCollision = |multiHit;

  for (genvar q = 0; q < NUM_RD; q++) begin : g_read
    assign rd_data[q*WIDTH +: WIDTH] = words[rd_addr[q*AW +: AW]];
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      wr_collision  <= 1'b0;
      collision_cnt <= '0;
    end else begin
      wr_collision <= anyCollision;
      if (anyCollision && (collision_cnt != {CNT_W{1'b1}}))
        collision_cnt <= collision_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vliw_regfile_mp.sv
// Directed self-checking bench for vliw_regfile_mp (default parameters).
module tb_vliw_regfile_mp;

  localparam int WIDTH  = 32;
  localparam int NUM_RD = 4;
  localparam int NUM_WR = 2;
  localparam int AW     = 3;

  logic                    clk;
  logic                    reset;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic                    wr_collision;
  logic [15:0]             collision_cnt;

  int tests_run;
  int tests_failed;

  vliw_regfile_mp dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_collision  (wr_collision),
    .collision_cnt (collision_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: state changes on negedge; inputs move and outputs are sampled 1 unit later
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] en, input logic [2:0] a0, input logic [31:0] d0,
                          input logic [2:0] a1, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1,
                        input logic [2:0] a2, input logic [2:0] a3);
    rd_addr = {a3, a2, a1, a0};
    #1;
  endtask

  function automatic logic [31:0] rd_port(input int q);
    return rd_data[q*WIDTH +: WIDTH];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_r0;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    drive_wr(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    rd_addr = '0;

    // reset held for two falling edges
    tick();
    tick();
    reset = 1'b0;
    check("reset_collision", {31'b0, wr_collision}, 32'h0);
    check("reset_cnt", {16'b0, collision_cnt}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      set_rd(3'(a), 3'(a), 3'(a), 3'(a));
      for (int q = 0; q < NUM_RD; q++) check($sformatf("reset_rd_a%0d_p%0d", a, q), rd_port(q), 32'h0);
    end

    // parallel writes to distinct words
    drive_wr(2'b11, 3'd3, 32'hDEADBEEF, 3'd5, 32'h12345678);
    tick();
    drive_wr(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    set_rd(3'd3, 3'd5, 3'd0, 3'd4);
    check("par_r3", rd_port(0), 32'hDEADBEEF);
    check("par_r5", rd_port(1), 32'h12345678);
    check("par_r0_untouched", rd_port(2), 32'h0);
    check("par_r4_untouched", rd_port(3), 32'h0);
    check("par_collision", {31'b0, wr_collision}, 32'h0);
    check("par_cnt", {16'b0, collision_cnt}, 32'h0);

    // collision: higher port wins
    drive_wr(2'b11, 3'd4, 32'h1111, 3'd4, 32'h2222);
    tick();
    drive_wr(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    set_rd(3'd4, 3'd3, 3'd5, 3'd4);
    check("col_r4", rd_port(0), 32'h2222);
    check("col_r3_kept", rd_port(1), 32'hDEADBEEF);
    check("col_r5_kept", rd_port(2), 32'h12345678);
    check("col_flag", {31'b0, wr_collision}, 32'h1);
    check("col_cnt", {16'b0, collision_cnt}, 32'h1);
    tick();
    check("col_flag_pulse_end", {31'b0, wr_collision}, 32'h0);
    check("col_cnt_hold", {16'b0, collision_cnt}, 32'h1);

    // single lower-port write with higher port idle still commits
    drive_wr(2'b01, 3'd6, 32'h0000BEEF, 3'd6, 32'hFFFFFFFF);
    tick();
    drive_wr(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    set_rd(3'd6, 3'd6, 3'd6, 3'd6);
    check("lone_p0_r6", rd_port(3), 32'h0000BEEF);
    check("lone_p0_nocol", {31'b0, wr_collision}, 32'h0);

    // reset overrides a concurrent write
    reset = 1'b1;
    drive_wr(2'b10, 3'd0, 32'h0, 3'd2, 32'hAAAA);
    tick();
    reset = 1'b0;
    drive_wr(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    set_rd(3'd2, 3'd3, 3'd4, 3'd5);
    check("rst_wr_r2", rd_port(0), 32'h0);
    check("rst_wr_r3", rd_port(1), 32'h0);
    check("rst_wr_r4", rd_port(2), 32'h0);
    check("rst_wr_cnt", {16'b0, collision_cnt}, 32'h0);
    drive_wr(2'b10, 3'd0, 32'h0, 3'd2, 32'hAAAA);
    tick();
    drive_wr(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    check("rewrite_r2", rd_port(0), 32'hAAAA);

    // r0 write: hardwired zero only when the option is built in
`ifdef VLIW_REGFILE_ZERO_R0_EN
    exp_r0 = 32'h0;
`else
    exp_r0 = 32'h5;
`endif
    drive_wr(2'b01, 3'd0, 32'h5, 3'd0, 32'h0);
    tick();
    drive_wr(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    set_rd(3'd0, 3'd2, 3'd0, 3'd0);
    check("r0_write", rd_port(0), exp_r0);
    check("r0_r2_kept", rd_port(1), 32'hAAAA);

    // counter saturation over 65540 collision edges
    drive_wr(2'b11, 3'd1, 32'h7, 3'd1, 32'h9);
    repeat (65534) tick();
    check("sat_cnt_fffe", {16'b0, collision_cnt}, 32'hFFFE);
    repeat (6) tick();
    check("sat_cnt_ffff", {16'b0, collision_cnt}, 32'hFFFF);
    check("sat_flag", {31'b0, wr_collision}, 32'h1);
    set_rd(3'd1, 3'd1, 3'd1, 3'd1);
    check("sat_r1", rd_port(2), 32'h9);
    drive_wr(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    tick();
    check("sat_cnt_hold", {16'b0, collision_cnt}, 32'hFFFF);
    check("sat_flag_clear", {31'b0, wr_collision}, 32'h0);

    // reset clears a saturated counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("final_rst_cnt", {16'b0, collision_cnt}, 32'h0);
    check("final_rst_r1", rd_port(0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
